led_stream_ctrl: RTL and testbench
==================================

Name: led_stream_ctrl

Overview:
- Frame scheduler between the sector-averaging block and the WS2812 bit serializer.
- Runs the 4-phase nxt/trig/t_valid handshake once per LED, latches each colour, applies global brightness, reorders to GRB and starts the serializer.
- After the last LED it enforces the latch gap, then re-arms rdy for the next frame.
- If the averaging block stops delivering (no video), it substitutes a fallback colour.

Parameters:
- NUM_LEDS, 48, LEDs per frame (num_h+2*num_v-2 of the averaging block).
- LATCH_CYC, 30000, idle cycles after the last pixel before the next frame (300 us at 100 MHz).
- TIMEOUT_CYC, 2000000, cycles in REQ without trig before the fallback engages.
- FALLBACK_RGB, 24'h000000, RGB colour sent in fallback.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- avg_rgb  in  24  {R,G,B} from the averaging block; valid while trig=1.
- trig  in  1  averaging block: colour available.
- nxt  out  1  request next LED colour.
- t_valid  out  1  colour taken, advance.
- rdy  out  1  high while the controller can accept a new frame.
- brightness  in  8  global scale; 255 means unity.
- px_data  out  24  {G,R,B} scaled pixel to the serializer.
- px_start  out  1  one-cycle start pulse to the serializer.
- px_busy  in  1  serializer shifting.
- frame_done  out  1  one-cycle pulse at the end of the latch gap.
- fallback_active  out  1  the current frame uses FALLBACK_RGB.

Behaviour:
- Reset (async, any state): state=IDLE; led_cnt=0; timer=0.
- Reset values: nxt=0, t_valid=0, rdy=0, px_data=0, px_start=0, frame_done=0, fallback_active=0.
- IDLE: one cycle, then go to REQ.
- REQ:
  - Drive nxt=1.
  - rdy=1 only when led_cnt==0.
  - Timer counts every cycle.
  - When trig=1: capture avg_rgb into col_reg, clear the timer, drop nxt, go to ACK.
  - If the timer reaches TIMEOUT_CYC: set fallback_active, drop nxt, go to SEND with col_reg=FALLBACK_RGB.
- ACK:
  - Drive t_valid=1 and nxt=0 (nxt must be low before t_valid rises; otherwise the averaging block re-arms trig).
  - When trig=0: drop t_valid, go to SEND.
- SEND:
  - Wait for px_busy=0, then pulse px_start for 1 cycle with px_data valid in the same cycle.
  - Go to WAIT.
- WAIT:
  - Wait one cycle for px_busy to rise, then wait for px_busy=0.
  - led_cnt++.
  - If led_cnt==NUM_LEDS go to LATCH.
  - Else, if fallback_active, go to SEND with FALLBACK_RGB; otherwise go to REQ.
- LATCH:
  - Count LATCH_CYC cycles with no px_start.
  - Then pulse frame_done, clear led_cnt and fallback_active, go to IDLE.
- Brightness arithmetic:
  - Each channel out = (c*(brightness+1))>>8, with a 16-bit product and 8-bit truncation.
  - brightness is sampled at the capture in REQ or fallback entry, so a change mid-pixel has no effect until the next pixel.
- px_data ordering: {G',R',B'}, taken from avg_rgb[15:8], [23:16], [7:0].
- Timeout mid-frame (led_cnt>0): the remaining LEDs of that frame get FALLBACK_RGB. The next frame retries the handshake starting in REQ.
- trig already high on entering REQ: capture on the first REQ cycle; this is legal.
- trig dropping during REQ before capture: ignored; stay in REQ.
- Throughput: at most one handshake per LED; nxt never overlaps t_valid.
- Timer and led_cnt saturate; they never wrap.

Test Plan:
- Handshake:
  - Stimulus: NUM_LEDS=4, brightness=255, model with a 2-FF-synchronized responder supplying 24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0.
  - Required: px_data sequence 24'h201030, 24'h504060, 24'h807090, 24'hB0A0C0.
  - Required: exactly 4 px_start pulses, then frame_done after LATCH_CYC cycles.
- Brightness:
  - Stimulus: brightness=127, avg_rgb=24'hFF8001.
  - Required: px_data=24'h407F00 (R=FF→7F, G=80→40, B=01→00).
- Fallback:
  - Stimulus: no trig, TIMEOUT_CYC=100, FALLBACK_RGB=24'h0000FF.
  - Required: fallback_active=1 at cycle 100.
  - Required: NUM_LEDS pixels of 24'h0000FF, then frame_done.
  - Required: the next frame re-asserts nxt.
- Mid-frame timeout:
  - Stimulus: trig stops after LED 1.
  - Required: LEDs 2..NUM_LEDS-1 get FALLBACK_RGB; led_cnt ends at NUM_LEDS.
- Protocol checks (assertions, any stimulus):
  - nxt&&t_valid never 1.
  - rdy=0 whenever led_cnt>0.
  - No px_start while px_busy=1 or during LATCH.
- Reset mid-operation:
  - Stimulus: assert rst during WAIT with led_cnt=2.
  - Required: all outputs 0 asynchronously; after release, the first nxt arrives 2 cycles later with led_cnt=0.

Source files
------------

// File: rtl/led_stream_ctrl_if.sv
// Pixel-stream bundle: the nxt/trig/t_valid colour handshake with the averaging
// block plus the px_data/px_start/px_busy link to the WS2812 serializer.
interface led_stream_ctrl_if;
  logic [23:0] avg_rgb;
  logic        trig;
  logic        nxt;
  logic        t_valid;
  logic [23:0] px_data;
  logic        px_start;
  logic        px_busy;

  modport master (
    input  avg_rgb, trig, px_busy,
    output nxt, t_valid, px_data, px_start
  );

  modport slave (
    output avg_rgb, trig, px_busy,
    input  nxt, t_valid, px_data, px_start
  );
endinterface

// File: rtl/led_stream_ctrl.sv
// Frame scheduler between the sector-averaging block and the WS2812 serializer:
// one colour handshake per LED, brightness scaling, GRB reorder and latch gap.
module led_stream_ctrl #(
  parameter int unsigned NUM_LEDS     = 48,
  parameter int unsigned LATCH_CYC    = 30000,
  parameter int unsigned TIMEOUT_CYC  = 2000000,
  parameter logic [23:0] FALLBACK_RGB = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  led_stream_ctrl_if.master bus,
  input  logic [7:0]        brightness,
  output logic              rdy,
  output logic              frame_done,
  output logic              fallback_active
);
  localparam int unsigned      CNT_W        = $clog2(NUM_LEDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(NUM_LEDS);
  localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0]      LATCH_LAST   = 32'(LATCH_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ACK, S_SEND, S_WAIT_RISE, S_WAIT_FALL, S_LATCH
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] led_cnt, led_cnt_nx, led_cnt_inc;
  logic [31:0]      timer, timer_nx, timer_inc;
  logic [23:0]      col_reg, col_nx;
  logic [23:0]      px_data, px_data_nx;
  logic             nxt, nxt_nx, t_valid, t_valid_nx, rdy_nx;
  logic             px_start, px_start_nx, frame_done_nx, fallback_nx;

  // Scale each channel by (brightness+1)/256 and reorder {R,G,B} to {G,R,B}.
  function automatic logic [23:0] scale_grb(input logic [23:0] rgb, input logic [7:0] b);
    logic [15:0] k, pr, pg, pb;
    k  = 16'({1'b0, b} + 9'd1);
    pr = 16'(rgb[23:16]) * k;
    pg = 16'(rgb[15:8])  * k;
    pb = 16'(rgb[7:0])   * k;
    return {pg[15:8], pr[15:8], pb[15:8]};
  endfunction

  assign led_cnt_inc = (led_cnt == {CNT_W{1'b1}}) ? led_cnt : led_cnt + CNT_W'(1'b1);
  assign timer_inc   = (timer == 32'hFFFF_FFFF) ? timer : timer + 32'd1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, datapath updates and look-ahead values for the registered outputs.
  always_comb begin
    state_nx      = state;
    led_cnt_nx    = led_cnt;
    timer_nx      = timer;
    col_nx        = col_reg;
    px_data_nx    = px_data;
    px_start_nx   = 1'b0;
    frame_done_nx = 1'b0;
    fallback_nx   = fallback_active;
    case (state)
      S_IDLE: begin
        timer_nx = 32'd0;
        state_nx = S_REQ;
      end
      S_REQ: begin
        if (bus.trig) begin
          col_nx   = scale_grb(bus.avg_rgb, brightness);
          timer_nx = 32'd0;
          state_nx = S_ACK;
        end else if (timer >= TIMEOUT_LAST) begin
          fallback_nx = 1'b1;
          col_nx      = scale_grb(FALLBACK_RGB, brightness);
          timer_nx    = 32'd0;
          state_nx    = S_SEND;
        end else begin
          timer_nx = timer_inc;
        end
      end
      S_ACK: begin
        if (!bus.trig) begin
          state_nx = S_SEND;
        end else begin
          state_nx = S_ACK;
        end
      end
      S_SEND: begin
        if (!bus.px_busy) begin
          px_start_nx = 1'b1;
          px_data_nx  = col_reg;
          state_nx    = S_WAIT_RISE;
        end else begin
          state_nx = S_SEND;
        end
      end
      S_WAIT_RISE: begin
        state_nx = S_WAIT_FALL;
      end
      S_WAIT_FALL: begin
        if (!bus.px_busy) begin
          led_cnt_nx = led_cnt_inc;
          timer_nx   = 32'd0;
          if (led_cnt_inc == LAST_CNT) begin
            state_nx = S_LATCH;
          end else if (fallback_active) begin
            col_nx   = scale_grb(FALLBACK_RGB, brightness);
            state_nx = S_SEND;
          end else begin
            state_nx = S_REQ;
          end
        end else begin
          state_nx = S_WAIT_FALL;
        end
      end
      S_LATCH: begin
        if (timer >= LATCH_LAST) begin
          frame_done_nx = 1'b1;
          led_cnt_nx    = {CNT_W{1'b0}};
          fallback_nx   = 1'b0;
          timer_nx      = 32'd0;
          state_nx      = S_IDLE;
        end else begin
          timer_nx = timer_inc;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    // Handshake strobes rise one cycle into their state, so nxt is always low before t_valid.
    nxt_nx     = (state == S_REQ) && (state_nx == S_REQ);
    t_valid_nx = (state == S_ACK) && (state_nx == S_ACK);
    rdy_nx     = nxt_nx && (led_cnt == {CNT_W{1'b0}});
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_cnt         <= {CNT_W{1'b0}};
      timer           <= 32'd0;
      col_reg         <= 24'h000000;
      px_data         <= 24'h000000;
      px_start        <= 1'b0;
      nxt             <= 1'b0;
      t_valid         <= 1'b0;
      rdy             <= 1'b0;
      frame_done      <= 1'b0;
      fallback_active <= 1'b0;
    end else begin
      led_cnt         <= led_cnt_nx;
      timer           <= timer_nx;
      col_reg         <= col_nx;
      px_data         <= px_data_nx;
      px_start        <= px_start_nx;
      nxt             <= nxt_nx;
      t_valid         <= t_valid_nx;
      rdy             <= rdy_nx;
      frame_done      <= frame_done_nx;
      fallback_active <= fallback_nx;
    end
  end

  assign bus.nxt      = nxt;
  assign bus.t_valid  = t_valid;
  assign bus.px_data  = px_data;
  assign bus.px_start = px_start;
endmodule

// File: tb/tb_led_stream_ctrl.sv
// Directed bench: synchronized colour responder, busy-counting serializer model,
// and one task per scenario with hand-computed expectations.
module tb_led_stream_ctrl;
  localparam int NUM     = 4;
  localparam int LATCH   = 20;
  localparam int TIMEOUT = 100;
  localparam int SER     = 8;
  localparam logic [23:0] FB_RGB = 24'h0000FF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] brightness = 8'd255;
  logic       rdy, frame_done, fallback_active;

  led_stream_ctrl_if bus ();

  led_stream_ctrl #(
    .NUM_LEDS(NUM), .LATCH_CYC(LATCH), .TIMEOUT_CYC(TIMEOUT), .FALLBACK_RGB(FB_RGB)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .brightness(brightness),
    .rdy(rdy), .frame_done(frame_done), .fallback_active(fallback_active)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Averaging-block model: 2-FF synchronizers on nxt and t_valid.
  logic [23:0] tbl [4];
  bit          resp_en = 1'b0;
  int          resp_limit = 1000;
  logic        nxt_s1, nxt_s2, tv_s1, tv_s2, trig_r;
  logic [23:0] avg_r;
  int          idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      nxt_s1 <= 1'b0; nxt_s2 <= 1'b0; tv_s1 <= 1'b0; tv_s2 <= 1'b0;
      trig_r <= 1'b0; avg_r <= 24'h0; idx <= 0;
    end else begin
      nxt_s1 <= bus.nxt;  nxt_s2 <= nxt_s1;
      tv_s1  <= bus.t_valid; tv_s2 <= tv_s1;
      if (!trig_r && nxt_s2 && !tv_s2 && resp_en && idx < resp_limit) begin
        trig_r <= 1'b1;
        avg_r  <= tbl[idx % 4];
      end else if (trig_r && tv_s2) begin
        trig_r <= 1'b0;
        idx    <= idx + 1;
      end
    end
  end
  assign bus.trig    = trig_r;
  assign bus.avg_rgb = avg_r;

  // Serializer model: busy for SER cycles after each start pulse.
  int busy_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (bus.px_start) busy_cnt <= SER;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.px_busy = (busy_cnt != 0);

  // Cycle counter, pixel log and protocol monitor.
  int          cyc = 0;
  logic [23:0] px_log [$];
  int          frame_px = 0, viol = 0, fd_cnt = 0, fd_cyc = 0, last_px_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      frame_px <= 0;
    end else begin
      viol <= viol + ((bus.nxt && bus.t_valid) ? 1 : 0)
                   + ((rdy && frame_px != 0) ? 1 : 0)
                   + ((bus.px_start && (bus.px_busy || frame_px >= NUM)) ? 1 : 0);
      if (bus.px_start) begin
        px_log.push_back(bus.px_data);
        last_px_cyc <= cyc;
        frame_px    <= frame_px + 1;
      end else if (frame_done) begin
        fd_cnt   <= fd_cnt + 1;
        fd_cyc   <= cyc;
        frame_px <= 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_frame(input int budget, output bit ok);
    int start;
    start = fd_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fd_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    total++;
    if ({bus.nxt, bus.t_valid, rdy, bus.px_start, frame_done, fallback_active} !== 6'b0 ||
        bus.px_data !== 24'h0) begin
      bad++;
      $display("FAIL reset_state: nxt=%b t_valid=%b rdy=%b px_start=%b frame_done=%b fb=%b px_data=%h, required all 0",
               bus.nxt, bus.t_valid, rdy, bus.px_start, frame_done, fallback_active, bus.px_data);
    end
  endtask

  task automatic test_handshake();
    logic [23:0] exp [4];
    logic [23:0] got;
    int base;
    bit ok;
    exp[0] = 24'h201030; exp[1] = 24'h504060; exp[2] = 24'h807090; exp[3] = 24'hB0A0C0;
    tbl[0] = 24'h102030; tbl[1] = 24'h405060; tbl[2] = 24'h708090; tbl[3] = 24'hA0B0C0;
    brightness = 8'd255; resp_en = 1'b1; resp_limit = 1000;
    base = px_log.size();
    apply_reset();
    wait_frame(3000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL hs_frame_done: no frame_done within 3000 cycles, required one"); end
    total++;
    if (px_log.size() - base !== NUM) begin
      bad++; $display("FAIL hs_px_count: got %0d pulses, required %0d", px_log.size() - base, NUM);
    end
    for (int i = 0; i < NUM; i++) begin
      got = (base + i < px_log.size()) ? px_log[base + i] : 24'hxxxxxx;
      total++;
      if (got !== exp[i]) begin bad++; $display("FAIL hs_px%0d: got %h, required %h", i, got, exp[i]); end
    end
    // Serializer busy SER cycles, one cycle to see busy low, LATCH idle cycles, one to register the pulse.
    total++;
    if (fd_cyc - last_px_cyc !== SER + LATCH + 2) begin
      bad++; $display("FAIL hs_latch_gap: got %0d cycles, required %0d", fd_cyc - last_px_cyc, SER + LATCH + 2);
    end
  endtask

  task automatic test_brightness();
    logic [23:0] got;
    int base;
    bit ok;
    for (int i = 0; i < 4; i++) tbl[i] = 24'hFF8001;
    brightness = 8'd127; resp_en = 1'b1; resp_limit = 1000;
    base = px_log.size();
    apply_reset();
    wait_frame(3000, ok);
    for (int i = 0; i < 2; i++) begin
      got = (base + i < px_log.size()) ? px_log[base + i] : 24'hxxxxxx;
      total++;
      if (got !== 24'h407F00) begin bad++; $display("FAIL bright_px%0d: got %h, required 407f00", i, got); end
    end
    brightness = 8'd255;
  endtask

  task automatic test_fallback();
    logic [23:0] got;
    int base;
    bit ok, seen;
    resp_en = 1'b0;
    base = px_log.size();
    apply_reset();
    tick(TIMEOUT);
    total++;
    if (fallback_active !== 1'b0) begin bad++; $display("FAIL fb_early: fallback_active=%b, required 0", fallback_active); end
    tick(1);
    total++;
    if (fallback_active !== 1'b1) begin bad++; $display("FAIL fb_at_timeout: fallback_active=%b, required 1", fallback_active); end
    wait_frame(1000, ok);
    total++;
    if (!ok || px_log.size() - base !== NUM) begin
      bad++; $display("FAIL fb_frame: done=%b pulses=%0d, required 1 and %0d", ok, px_log.size() - base, NUM);
    end
    for (int i = 0; i < NUM; i++) begin
      got = (base + i < px_log.size()) ? px_log[base + i] : 24'hxxxxxx;
      total++;
      if (got !== FB_RGB) begin bad++; $display("FAIL fb_px%0d: got %h, required %h", i, got, FB_RGB); end
    end
    total++;
    if (fallback_active !== 1'b0) begin bad++; $display("FAIL fb_clear: fallback_active=%b, required 0", fallback_active); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.nxt;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL fb_next_nxt: nxt stayed 0, required 1 within 10 cycles"); end
  endtask

  task automatic test_mid_frame_timeout();
    logic [23:0] exp [4];
    logic [23:0] got;
    int base;
    bit ok;
    exp[0] = 24'h201030; exp[1] = 24'h504060; exp[2] = FB_RGB; exp[3] = FB_RGB;
    tbl[0] = 24'h102030; tbl[1] = 24'h405060; tbl[2] = 24'h708090; tbl[3] = 24'hA0B0C0;
    resp_en = 1'b1; resp_limit = 2;
    base = px_log.size();
    apply_reset();
    wait_frame(3000, ok);
    total++;
    if (!ok || px_log.size() - base !== NUM) begin
      bad++; $display("FAIL mid_frame: done=%b pulses=%0d, required 1 and %0d", ok, px_log.size() - base, NUM);
    end
    for (int i = 0; i < NUM; i++) begin
      got = (base + i < px_log.size()) ? px_log[base + i] : 24'hxxxxxx;
      total++;
      if (got !== exp[i]) begin bad++; $display("FAIL mid_px%0d: got %h, required %h", i, got, exp[i]); end
    end
    resp_limit = 1000;
  endtask

  task automatic test_reset_mid_frame();
    int base;
    bit ok;
    for (int i = 0; i < 4; i++) tbl[i] = 24'h123456;
    resp_en = 1'b1; resp_limit = 1000;
    base = px_log.size();
    apply_reset();
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = (px_log.size() - base >= 3);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL rstmid_reach: third pixel not seen within 2000 cycles"); end
    tick(2);
    rst = 1'b1;
    #1;
    total++;
    if ({bus.nxt, bus.t_valid, rdy, bus.px_start, frame_done, fallback_active} !== 6'b0 ||
        bus.px_data !== 24'h0) begin
      bad++;
      $display("FAIL rstmid_async: nxt=%b t_valid=%b rdy=%b px_start=%b frame_done=%b fb=%b px_data=%h, required all 0",
               bus.nxt, bus.t_valid, rdy, bus.px_start, frame_done, fallback_active, bus.px_data);
    end
    tick(2);
    rst = 1'b0;
    tick(1);
    total++;
    if (bus.nxt !== 1'b0) begin bad++; $display("FAIL rstmid_nxt_c1: nxt=%b, required 0", bus.nxt); end
    tick(1);
    total++;
    if (bus.nxt !== 1'b1 || rdy !== 1'b1) begin
      bad++; $display("FAIL rstmid_nxt_c2: nxt=%b rdy=%b, required 1 1", bus.nxt, rdy);
    end
  endtask

  task automatic test_protocol();
    total++;
    if (viol !== 0) begin bad++; $display("FAIL protocol: %0d violations, required 0", viol); end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_brightness();
    test_fallback();
    test_mid_frame_timeout();
    test_reset_mid_frame();
    tick(5);
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
